// File: rtl/matrix_mult_lanes.sv
// rtl/matrix_mult_lanes.sv - multi-lane matrix multiply engine C = A x B with saturation
//
// Computes one row of C per pass: reads row m of A, then walks the B^T weight
// groups, producing LANES output features per group, and writes the row out.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, signedMode   job request (sampled in IDLE), operand mode captured on accept
//   inputData           row of A from the A buffer (1-cycle synchronous read)
//   weightData          LANES rows of B^T from the weight buffer (1-cycle synchronous read)
//   inputAddr           A row read address
//   weightAddr          weight group read address
//   outputData          row of C, held between writes
//   outputAddr          C row write address
//   outputWrEn          one-cycle write strobe
//   busy, done          job in progress, one-cycle completion pulse
//   satFlag             sticky saturation indicator for the current/last job
module matrix_mult_lanes #(
    parameter int BATCH_SIZE          = 8,
    parameter int LOG_BATCH_SIZE      = 3,
    parameter int INPUT_FEATURES      = 4,
    parameter int LOG_INPUT_FEATURES  = 2,
    parameter int OUTPUT_FEATURES     = 8,
    parameter int LOG_OUTPUT_FEATURES = 3,
    parameter int LANES               = 2,
    parameter int LOG_LANES           = 1,
    parameter int INPUT_WIDTH         = 4,
    parameter int WEIGHT_WIDTH        = 8,
    parameter int OUTPUT_WIDTH        = 16
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    input  logic                                          signedMode,
    input  logic [INPUT_FEATURES*INPUT_WIDTH-1:0]         inputData,
    input  logic [LANES*INPUT_FEATURES*WEIGHT_WIDTH-1:0]  weightData,
    output logic [LOG_BATCH_SIZE-1:0]                     inputAddr,
    output logic [LOG_OUTPUT_FEATURES-LOG_LANES-1:0]      weightAddr,
    output logic [OUTPUT_FEATURES*OUTPUT_WIDTH-1:0]       outputData,
    output logic [LOG_BATCH_SIZE-1:0]                     outputAddr,
    output logic                                          outputWrEn,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          satFlag
);

    localparam int GROUPS = OUTPUT_FEATURES / LANES;
    localparam int GW     = LOG_OUTPUT_FEATURES - LOG_LANES;
    localparam int PW     = INPUT_WIDTH + WEIGHT_WIDTH;
    localparam int ACCW   = PW + LOG_INPUT_FEATURES;
    // Wide enough to hold any accumulator value and both clamp bounds.
    localparam int WIDE   = ACCW + OUTPUT_WIDTH + 1;
    localparam int ROWW   = OUTPUT_FEATURES * OUTPUT_WIDTH;
    localparam int LANEW  = INPUT_FEATURES * WEIGHT_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        DRAIN,
        WRITE
    } state_t;

    state_t                state;
    state_t                nextState;
    logic [LOG_BATCH_SIZE-1:0] rowCnt;
    logic [GW-1:0]         group;
    logic                  modeSigned;
    // Group issued in the previous cycle; its weights are valid this cycle.
    logic                  issuedValid;
    logic [GW-1:0]         issuedGroup;
    logic [ROWW-1:0]       rowBuffer;
    logic [ROWW-1:0]       rowNext;
    logic [ROWW-1:0]       outRow;
    logic                  doneReg;
    logic                  satReg;
    logic                  satHit;
    logic [OUTPUT_WIDTH:0] laneOut [LANES];

    // Dot product of one A row with one B^T row, saturated to OUTPUT_WIDTH.
    // Returns {clamped, result}. Products are formed on sign/zero-extended
    // operands; the low PW bits are exact for both modes.
    function automatic logic [OUTPUT_WIDTH:0] laneDot(
        input logic [INPUT_FEATURES*INPUT_WIDTH-1:0] row,
        input logic [LANEW-1:0]                      wts,
        input logic                                  sgn
    );
        logic [INPUT_WIDTH-1:0]  a;
        logic [WEIGHT_WIDTH-1:0] w;
        logic [PW-1:0]           aExt;
        logic [PW-1:0]           wExt;
        logic [PW-1:0]           prod;
        logic [ACCW-1:0]         acc;
        logic [WIDE-1:0]         wide;
        logic [WIDE-1:0]         maxU;
        logic [WIDE-1:0]         maxS;
        logic [WIDE-1:0]         minS;
        logic [OUTPUT_WIDTH-1:0] res;
        logic                    sat;
        acc = '0;
        for (int k = 0; k < INPUT_FEATURES; k++) begin
            a    = row[k*INPUT_WIDTH +: INPUT_WIDTH];
            w    = wts[k*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            aExt = sgn ? {{WEIGHT_WIDTH{a[INPUT_WIDTH-1]}}, a} : {{WEIGHT_WIDTH{1'b0}}, a};
            wExt = sgn ? {{INPUT_WIDTH{w[WEIGHT_WIDTH-1]}}, w} : {{INPUT_WIDTH{1'b0}}, w};
            prod = aExt * wExt;
            acc  = acc + (sgn ? {{LOG_INPUT_FEATURES{prod[PW-1]}}, prod}
                              : {{LOG_INPUT_FEATURES{1'b0}}, prod});
        end
        wide = sgn ? {{(WIDE-ACCW){acc[ACCW-1]}}, acc} : {{(WIDE-ACCW){1'b0}}, acc};
        maxU = {{(WIDE-OUTPUT_WIDTH){1'b0}}, {OUTPUT_WIDTH{1'b1}}};
        maxS = {{(WIDE-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
        minS = {{(WIDE-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};
        sat  = 1'b0;
        res  = wide[OUTPUT_WIDTH-1:0];
        if (sgn) begin
            if ($signed(wide) > $signed(maxS)) begin
                res = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
                sat = 1'b1;
            end else if ($signed(wide) < $signed(minS)) begin
                res = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
                sat = 1'b1;
            end
        end else if (wide > maxU) begin
            res = {OUTPUT_WIDTH{1'b1}};
            sat = 1'b1;
        end
        return {sat, res};
    endfunction

    for (genvar l = 0; l < LANES; l++) begin : gLane
        assign laneOut[l] = laneDot(inputData, weightData[l*LANEW +: LANEW], modeSigned);
    end

    // Merge the lanes of the group whose weights arrived this cycle into the row.
    always_comb begin
        rowNext = rowBuffer;
        satHit  = 1'b0;
        if (issuedValid) begin
            for (int l = 0; l < LANES; l++) begin
                rowNext[(int'(issuedGroup)*LANES + l)*OUTPUT_WIDTH +: OUTPUT_WIDTH] =
                    laneOut[l][OUTPUT_WIDTH-1:0];
                satHit = satHit | laneOut[l][OUTPUT_WIDTH];
            end
        end
    end

    always_comb begin
        nextState  = state;
        busy       = (state != IDLE);
        outputWrEn = (state == WRITE);
        case (state)
            IDLE:    if (start) nextState = LOAD;
            LOAD:    nextState = ISSUE;
            ISSUE:   if (group == GW'(GROUPS - 1)) nextState = DRAIN;
            DRAIN:   nextState = WRITE;
            WRITE:   nextState = (rowCnt == LOG_BATCH_SIZE'(BATCH_SIZE - 1)) ? IDLE : LOAD;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rowCnt      <= '0;
            group       <= '0;
            modeSigned  <= 1'b0;
            issuedValid <= 1'b0;
            issuedGroup <= '0;
            rowBuffer   <= '0;
            outRow      <= '0;
            doneReg     <= 1'b0;
            satReg      <= 1'b0;
        end else begin
            state       <= nextState;
            doneReg     <= 1'b0;
            issuedValid <= (state == ISSUE);
            issuedGroup <= group;
            rowBuffer   <= rowNext;
            if (state == DRAIN) outRow <= rowNext;
            if (satHit) satReg <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        rowCnt     <= '0;
                        group      <= '0;
                        modeSigned <= signedMode;
                        satReg     <= 1'b0;
                    end
                end
                ISSUE: begin
                    group <= (group == GW'(GROUPS - 1)) ? '0 : group + 1'b1;
                end
                WRITE: begin
                    if (rowCnt == LOG_BATCH_SIZE'(BATCH_SIZE - 1)) doneReg <= 1'b1;
                    else rowCnt <= rowCnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign inputAddr  = rowCnt;
    assign outputAddr = rowCnt;
    assign weightAddr = group;
    assign outputData = outRow;
    assign done       = doneReg;
    assign satFlag    = satReg;

endmodule

// File: tb/tb_matrix_mult_lanes.sv
// tb/tb_matrix_mult_lanes.sv - directed bench for matrix_mult_lanes (OW=16 and OW=12 instances)
module tb_matrix_mult_lanes;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, signedMode, start12, signedMode12;
    logic [15:0]  inputData, inputData12;
    logic [63:0]  weightData, weightData12;
    logic [2:0]   inputAddr, inputAddr12, outputAddr, outputAddr12;
    logic [1:0]   weightAddr, weightAddr12;
    logic [127:0] outputData;
    logic [95:0]  outputData12;
    logic outputWrEn, busy, done, satFlag;
    logic outputWrEn12, busy12, done12, satFlag12;

    matrix_mult_lanes dut (
        .clk(clk), .rst(rst), .start(start), .signedMode(signedMode),
        .inputData(inputData), .weightData(weightData),
        .inputAddr(inputAddr), .weightAddr(weightAddr),
        .outputData(outputData), .outputAddr(outputAddr), .outputWrEn(outputWrEn),
        .busy(busy), .done(done), .satFlag(satFlag)
    );

    matrix_mult_lanes #(.OUTPUT_WIDTH(12)) dut12 (
        .clk(clk), .rst(rst), .start(start12), .signedMode(signedMode12),
        .inputData(inputData12), .weightData(weightData12),
        .inputAddr(inputAddr12), .weightAddr(weightAddr12),
        .outputData(outputData12), .outputAddr(outputAddr12), .outputWrEn(outputWrEn12),
        .busy(busy12), .done(done12), .satFlag(satFlag12)
    );

    logic [15:0] memA [8];
    logic [63:0] memB [4];

    always @(posedge clk) begin
        inputData    <= memA[inputAddr];
        weightData   <= memB[weightAddr];
        inputData12  <= memA[inputAddr12];
        weightData12 <= memB[weightAddr12];
    end

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int wrAddr[$];
    int wrCycle[$];
    logic [127:0] wrData[$];
    int wr12Addr[$];
    int wr12Cycle[$];
    logic [95:0] wr12Data[$];

    always @(negedge clk) begin
        if (outputWrEn === 1'b1) begin
            wrAddr.push_back(int'(outputAddr));
            wrCycle.push_back(cycle);
            wrData.push_back(outputData);
        end
        if (outputWrEn12 === 1'b1) begin
            wr12Addr.push_back(int'(outputAddr12));
            wr12Cycle.push_back(cycle);
            wr12Data.push_back(outputData12);
        end
    end

    int checks = 0;
    int fails = 0;
    int startCycle, doneCycle, startCycle12, doneCycle12;

    function automatic logic [127:0] rep16(input logic [15:0] v);
        logic [127:0] r;
        for (int o = 0; o < 8; o++) r[o*16 +: 16] = v;
        return r;
    endfunction

    function automatic logic [95:0] rep12(input logic [11:0] v);
        logic [95:0] r;
        for (int o = 0; o < 8; o++) r[o*12 +: 12] = v;
        return r;
    endfunction

    task automatic fill_uniform(input logic [3:0] a, input logic [7:0] w);
        for (int m = 0; m < 8; m++) memA[m] = {4{a}};
        for (int g = 0; g < 4; g++) memB[g] = {8{w}};
    endtask

    task automatic clear_writes;
        wrAddr.delete(); wrCycle.delete(); wrData.delete();
        wr12Addr.delete(); wr12Cycle.delete(); wr12Data.delete();
    endtask

    task automatic start_main(input logic sm);
        @(negedge clk); start = 1'b1; signedMode = sm;
        @(negedge clk); start = 1'b0; startCycle = cycle;
    endtask

    task automatic start_12(input logic sm);
        @(negedge clk); start12 = 1'b1; signedMode12 = sm;
        @(negedge clk); start12 = 1'b0; startCycle12 = cycle;
    endtask

    task automatic wait_done_main;
        int n = 0;
        while (done !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (done !== 1'b1) begin fails++; $display("FAIL done_timeout: done=%b required 1", done); end
        doneCycle = cycle;
    endtask

    task automatic wait_done_12;
        int n = 0;
        while (done12 !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (done12 !== 1'b1) begin fails++; $display("FAIL done12_timeout: done=%b required 1", done12); end
        doneCycle12 = cycle;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; signedMode = 1'b0; start12 = 1'b0; signedMode12 = 1'b0;
        fill_uniform(4'h0, 8'h00);
        repeat (3) @(negedge clk);
        checks++;
        if ({outputWrEn, busy, done, satFlag, inputAddr, weightAddr, outputAddr} !== 13'd0 || outputData !== 128'd0) begin
            fails++; $display("FAIL reset_main: ctl=%h data=%h required 0", {outputWrEn, busy, done, satFlag, inputAddr, weightAddr, outputAddr}, outputData);
        end
        checks++;
        if ({outputWrEn12, busy12, done12, satFlag12, inputAddr12, weightAddr12, outputAddr12} !== 13'd0 || outputData12 !== 96'd0) begin
            fails++; $display("FAIL reset_12: ctl=%h data=%h required 0", {outputWrEn12, busy12, done12, satFlag12, inputAddr12, weightAddr12, outputAddr12}, outputData12);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_unsigned_ones;
        fill_uniform(4'h1, 8'h02); clear_writes();
        start_main(1'b0);
        checks++;
        if (busy !== 1'b1) begin fails++; $display("FAIL busy_after_start: got %b required 1", busy); end
        wait_done_main();
        checks++;
        if (doneCycle - startCycle != 56) begin fails++; $display("FAIL job_latency: got %0d required 56", doneCycle - startCycle); end
        checks++;
        if (busy !== 1'b0) begin fails++; $display("FAIL busy_at_done: got %b required 0", busy); end
        checks++;
        if (satFlag !== 1'b0) begin fails++; $display("FAIL sat_ones: got %b required 0", satFlag); end
        checks++;
        if (wrAddr.size() != 8) begin fails++; $display("FAIL write_count_ones: got %0d required 8", wrAddr.size()); end
        for (int i = 0; i < wrAddr.size() && i < 8; i++) begin
            checks++;
            if (wrAddr[i] != i || wrData[i] !== rep16(16'd8) || wrCycle[i] != startCycle + 6 + 7*i) begin
                fails++; $display("FAIL row_ones[%0d]: addr=%0d cyc=%0d data=%h required addr=%0d cyc=%0d data=%h", i, wrAddr[i], wrCycle[i] - startCycle, wrData[i], i, 6 + 7*i, rep16(16'd8));
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin fails++; $display("FAIL done_width: got %b required 0", done); end
    endtask

    task automatic test_placement;
        logic [127:0] expRow;
        for (int m = 0; m < 8; m++) memA[m] = 16'(m + 1);
        for (int g = 0; g < 4; g++) begin
            memB[g] = 64'd0;
            memB[g][7:0]   = 8'(2*g + 1);
            memB[g][39:32] = 8'(2*g + 2);
        end
        clear_writes();
        start_main(1'b0);
        for (int g = 0; g < 4; g++) begin
            @(negedge clk);
            checks++;
            if (weightAddr !== 2'(g) || inputAddr !== 3'd0) begin
                fails++; $display("FAIL weight_addr_seq[%0d]: waddr=%0d iaddr=%0d required waddr=%0d iaddr=0", g, weightAddr, inputAddr, g);
            end
        end
        wait_done_main();
        checks++;
        if (wrAddr.size() != 8) begin fails++; $display("FAIL write_count_place: got %0d required 8", wrAddr.size()); end
        for (int i = 0; i < wrAddr.size() && i < 8; i++) begin
            for (int o = 0; o < 8; o++) expRow[o*16 +: 16] = 16'((i + 1) * (o + 1));
            checks++;
            if (wrAddr[i] != i || wrData[i] !== expRow) begin
                fails++; $display("FAIL row_place[%0d]: addr=%0d data=%h required addr=%0d data=%h", i, wrAddr[i], wrData[i], i, expRow);
            end
        end
    endtask

    task automatic test_signed_modes;
        logic [3:0]  aTab [3] = '{4'h8, 4'h8, 4'h8};
        logic [7:0]  wTab [3] = '{8'h80, 8'h80, 8'h7F};
        logic        sTab [3] = '{1'b1, 1'b0, 1'b0};
        logic [15:0] eTab [3] = '{16'd4096, 16'd4096, 16'd4064};
        for (int t = 0; t < 3; t++) begin
            fill_uniform(aTab[t], wTab[t]); clear_writes();
            start_main(sTab[t]);
            wait_done_main();
            checks++;
            if (satFlag !== 1'b0) begin fails++; $display("FAIL sat_mode[%0d]: got %b required 0", t, satFlag); end
            checks++;
            if (wrAddr.size() != 8) begin fails++; $display("FAIL write_count_mode[%0d]: got %0d required 8", t, wrAddr.size()); end
            for (int i = 0; i < wrAddr.size() && i < 8; i++) begin
                checks++;
                if (wrAddr[i] != i || wrData[i] !== rep16(eTab[t])) begin
                    fails++; $display("FAIL row_mode[%0d][%0d]: addr=%0d data=%h required addr=%0d data=%h", t, i, wrAddr[i], wrData[i], i, rep16(eTab[t]));
                end
            end
        end
    endtask

    task automatic test_saturation;
        logic [3:0]  aTab [2] = '{4'hF, 4'h8};
        logic [7:0]  wTab [2] = '{8'hFF, 8'h7F};
        logic        sTab [2] = '{1'b0, 1'b1};
        logic [11:0] eTab [2] = '{12'hFFF, 12'h800};
        for (int t = 0; t < 2; t++) begin
            fill_uniform(aTab[t], wTab[t]); clear_writes();
            start_12(sTab[t]);
            wait_done_12();
            checks++;
            if (satFlag12 !== 1'b1) begin fails++; $display("FAIL sat_flag[%0d]: got %b required 1", t, satFlag12); end
            checks++;
            if (wr12Addr.size() != 8) begin fails++; $display("FAIL write_count_sat[%0d]: got %0d required 8", t, wr12Addr.size()); end
            for (int i = 0; i < wr12Addr.size() && i < 8; i++) begin
                checks++;
                if (wr12Addr[i] != i || wr12Data[i] !== rep12(eTab[t])) begin
                    fails++; $display("FAIL row_sat[%0d][%0d]: addr=%0d data=%h required addr=%0d data=%h", t, i, wr12Addr[i], wr12Data[i], i, rep12(eTab[t]));
                end
            end
        end
    endtask

    task automatic test_start_ignored;
        fill_uniform(4'h1, 8'h02); clear_writes();
        start_main(1'b0);
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done_main();
        checks++;
        if (doneCycle - startCycle != 56) begin fails++; $display("FAIL restart_latency: got %0d required 56", doneCycle - startCycle); end
        checks++;
        if (wrAddr.size() != 8) begin fails++; $display("FAIL restart_count: got %0d required 8", wrAddr.size()); end
        for (int i = 0; i < wrAddr.size() && i < 8; i++) begin
            checks++;
            if (wrAddr[i] != i || wrData[i] !== rep16(16'd8)) begin
                fails++; $display("FAIL restart_row[%0d]: addr=%0d data=%h required addr=%0d data=%h", i, wrAddr[i], wrData[i], i, rep16(16'd8));
            end
        end
    endtask

    task automatic test_back_to_back;
        int d;
        fill_uniform(4'hF, 8'hFF); clear_writes();
        @(negedge clk); start12 = 1'b1; signedMode12 = 1'b0;
        @(negedge clk); startCycle12 = cycle;
        wait_done_12();
        d = doneCycle12;
        checks++;
        if (satFlag12 !== 1'b1 || busy12 !== 1'b0) begin
            fails++; $display("FAIL b2b_first_done: sat=%b busy=%b required sat=1 busy=0", satFlag12, busy12);
        end
        fill_uniform(4'h1, 8'h02); clear_writes();
        @(negedge clk); start12 = 1'b0;
        checks++;
        if (busy12 !== 1'b1 || satFlag12 !== 1'b0 || done12 !== 1'b0) begin
            fails++; $display("FAIL b2b_restart: busy=%b sat=%b done=%b required busy=1 sat=0 done=0", busy12, satFlag12, done12);
        end
        wait_done_12();
        checks++;
        if (doneCycle12 - d != 57) begin fails++; $display("FAIL b2b_latency: got %0d required 57", doneCycle12 - d); end
        checks++;
        if (satFlag12 !== 1'b0) begin fails++; $display("FAIL b2b_sat: got %b required 0", satFlag12); end
        checks++;
        if (wr12Addr.size() != 8) begin fails++; $display("FAIL b2b_count: got %0d required 8", wr12Addr.size()); end
        for (int i = 0; i < wr12Addr.size() && i < 8; i++) begin
            checks++;
            if (wr12Addr[i] != i || wr12Data[i] !== rep12(12'd8) || wr12Cycle[i] != d + 7 + 7*i) begin
                fails++; $display("FAIL b2b_row[%0d]: addr=%0d cyc=%0d data=%h required addr=%0d cyc=%0d data=%h", i, wr12Addr[i], wr12Cycle[i] - d, wr12Data[i], i, 7 + 7*i, rep12(12'd8));
            end
        end
    endtask

    task automatic test_reset_midjob;
        fill_uniform(4'h1, 8'h02); clear_writes();
        start_main(1'b0);
        repeat (23) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (outputWrEn !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || outputData !== 128'd0) begin
            fails++; $display("FAIL reset_abort: wr=%b busy=%b done=%b data=%h required 0", outputWrEn, busy, done, outputData);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (wrAddr.size() != 3 || done !== 1'b0) begin
            fails++; $display("FAIL reset_no_write: writes=%0d done=%b required writes=3 done=0", wrAddr.size(), done);
        end
        clear_writes();
        start_main(1'b0);
        checks++;
        if (inputAddr !== 3'd0 || busy !== 1'b1) begin
            fails++; $display("FAIL reset_restart: iaddr=%0d busy=%b required iaddr=0 busy=1", inputAddr, busy);
        end
        wait_done_main();
        checks++;
        if (wrAddr.size() != 8) begin fails++; $display("FAIL reset_restart_count: got %0d required 8", wrAddr.size()); end
        for (int i = 0; i < wrAddr.size() && i < 8; i++) begin
            checks++;
            if (wrAddr[i] != i || wrData[i] !== rep16(16'd8)) begin
                fails++; $display("FAIL reset_restart_row[%0d]: addr=%0d data=%h required addr=%0d data=%h", i, wrAddr[i], wrData[i], i, rep16(16'd8));
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_ones();
        test_placement();
        test_signed_modes();
        test_saturation();
        test_start_ignored();
        test_back_to_back();
        test_reset_midjob();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
